reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_if.sv | 40 ++++
 rtl/reg_file.sv | 78 +++++++
 tb/tb_reg_file.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// ---------------------------------------------------------------------------
// reg_file_if
//   Bundles the read/write/debug signals of the register file.
//   Signal names follow the register-file datapath naming
//   (readReg1/readReg2/writeReg/...).
//
//   slave  : the register file itself (takes indices and write data,
//            drives read data, debug data and the write counter)
//   master : the datapath / testbench driving it
//
//   Write qualification (there is no valid/ready pair here): a write is
//   "committed" exactly when regWrite=1 and writeReg!=0 at a rising clk
//   edge with reset low. There is no back-pressure, so every qualified
//   write is accepted in the cycle it is presented.
// ---------------------------------------------------------------------------
interface reg_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] readReg1;
  logic [ADDR_WIDTH-1:0] readReg2;
  logic [ADDR_WIDTH-1:0] writeReg;
  logic [DATA_WIDTH-1:0] writeData;
  logic                  regWrite;
  logic [ADDR_WIDTH-1:0] dbgAddr;
  logic [DATA_WIDTH-1:0] readData1;
  logic [DATA_WIDTH-1:0] readData2;
  logic [DATA_WIDTH-1:0] dbgData;
  logic [15:0]           wrCount;

  modport slave (
    input  readReg1, readReg2, writeReg, writeData, regWrite, dbgAddr,
    output readData1, readData2, dbgData, wrCount
  );

  modport master (
    output readReg1, readReg2, writeReg, writeData, regWrite, dbgAddr,
    input  readData1, readData2, dbgData, wrCount
  );
endinterface

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//   2**ADDR_WIDTH x DATA_WIDTH register file with r0 hard-wired to zero,
//   two combinational read ports with write-to-read bypass, a combinational
//   debug read port without bypass, and a saturating count of committed
//   writes.
//
//   Ports:
//     clk   : single clock, all state changes on its rising edge
//     reset : asynchronous, active-high; clears every register and wrCount
//     bus   : reg_file_if.slave (read indices, write index/data/enable,
//             debug index; read data, debug data, write count)
// ---------------------------------------------------------------------------
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic        clk,
  input  logic        reset,
  reg_file_if.slave   bus
);

  localparam int REG_COUNT = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
  logic [15:0]           wr_count_q;
  logic [15:0]           wr_count_d;

  // A write to r0 is dropped entirely: no storage update, no count, no bypass.
  logic commit;
  assign commit = bus.regWrite && (bus.writeReg != '0);

  always_comb begin
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    if (commit) begin
      regs_d[bus.writeReg] = bus.writeData;
      if (wr_count_q != 16'hFFFF) begin
        wr_count_d = wr_count_q + 16'd1;
      end
    end
  end

  // r0 is never loaded (commit excludes index 0), so it stays at its reset
  // value of zero and reads 0 on every port without extra masking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wr_count_q <= wr_count_d;
    end
  end

  // Bypass uses only the write-side inputs, so it stays active even while
  // reset holds the storage at zero.
  always_comb begin
    bus.readData1 = regs_q[bus.readReg1];
    bus.readData2 = regs_q[bus.readReg2];
    if (commit && (bus.writeReg == bus.readReg1)) begin
      bus.readData1 = bus.writeData;
    end
    if (commit && (bus.writeReg == bus.readReg2)) begin
      bus.readData2 = bus.writeData;
    end
  end

  // Debug port shows stored state only.
  assign bus.dbgData = regs_q[bus.dbgAddr];
  assign bus.wrCount = wr_count_q;

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
//   Directed bench for reg_file. Inputs change on the falling edge; outputs
//   are sampled 1ns after an input change or a rising edge.
// ---------------------------------------------------------------------------
module tb_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  reg_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // -------------------------------------------------------------------------
  // clock / reset
  // -------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // driver tasks
  // -------------------------------------------------------------------------
  task automatic drive_idle();
    bus.regWrite  = 1'b0;
    bus.writeReg  = '0;
    bus.writeData = '0;
    bus.readReg1  = '0;
    bus.readReg2  = '0;
    bus.dbgAddr   = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One committed-or-not write spanning one rising edge, then idle.
  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    bus.regWrite  = 1'b1;
    bus.writeReg  = addr;
    bus.writeData = data;
    @(posedge clk);
    #1;
    bus.regWrite  = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // tests
  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    #1;
    checks++;
    if (bus.wrCount !== 16'h0) begin
      failures++;
      $display("FAIL reset_wrcount actual=%h required=%h", bus.wrCount, 16'h0);
    end
    for (int a = 0; a < 32; a += 7) begin
      bus.dbgAddr  = AW'(a);
      bus.readReg1 = AW'(a);
      #1;
      checks++;
      if (bus.dbgData !== 32'h0 || bus.readData1 !== 32'h0) begin
        failures++;
        $display("FAIL reset_read addr=%0d dbg=%h rd1=%h required=0", a, bus.dbgData, bus.readData1);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_write_basic();
    do_write(5'd8, 32'h1234_5678);
    bus.dbgAddr = 5'd8;
    #1;
    checks++;
    if (bus.dbgData !== 32'h1234_5678) begin
      failures++;
      $display("FAIL write_basic_dbg actual=%h required=%h", bus.dbgData, 32'h1234_5678);
    end
    checks++;
    if (bus.wrCount !== 16'd1) begin
      failures++;
      $display("FAIL write_basic_count actual=%0d required=1", bus.wrCount);
    end
  endtask

  task automatic test_write_r0();
    do_write(5'd0, 32'hFFFF_FFFF);
    bus.readReg1 = 5'd0;
    bus.readReg2 = 5'd0;
    bus.dbgAddr  = 5'd0;
    #1;
    checks++;
    if (bus.readData1 !== 32'h0 || bus.readData2 !== 32'h0 || bus.dbgData !== 32'h0) begin
      failures++;
      $display("FAIL write_r0_read rd1=%h rd2=%h dbg=%h required=0",
               bus.readData1, bus.readData2, bus.dbgData);
    end
    checks++;
    if (bus.wrCount !== 16'd1) begin
      failures++;
      $display("FAIL write_r0_count actual=%0d required=1", bus.wrCount);
    end
    // r0 write must not bypass either
    @(negedge clk);
    bus.regWrite  = 1'b1;
    bus.writeReg  = 5'd0;
    bus.writeData = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (bus.readData1 !== 32'h0) begin
      failures++;
      $display("FAIL write_r0_bypass actual=%h required=0", bus.readData1);
    end
    bus.regWrite = 1'b0;
  endtask

  task automatic test_bypass();
    do_write(5'd9, 32'hA);
    @(negedge clk);
    bus.regWrite  = 1'b1;
    bus.writeReg  = 5'd9;
    bus.writeData = 32'hB;
    bus.readReg1  = 5'd9;
    bus.readReg2  = 5'd9;
    bus.dbgAddr   = 5'd9;
    #1;
    checks++;
    if (bus.readData1 !== 32'hB || bus.readData2 !== 32'hB) begin
      failures++;
      $display("FAIL bypass_both rd1=%h rd2=%h required=%h", bus.readData1, bus.readData2, 32'hB);
    end
    checks++;
    if (bus.dbgData !== 32'hA) begin
      failures++;
      $display("FAIL bypass_dbg_before actual=%h required=%h", bus.dbgData, 32'hA);
    end
    @(posedge clk);
    #1;
    bus.regWrite = 1'b0;
    #1;
    checks++;
    if (bus.dbgData !== 32'hB) begin
      failures++;
      $display("FAIL bypass_dbg_after actual=%h required=%h", bus.dbgData, 32'hB);
    end
    // independent bypass: only port 2 matches
    @(negedge clk);
    bus.regWrite  = 1'b1;
    bus.writeReg  = 5'd10;
    bus.writeData = 32'hC0DE;
    bus.readReg1  = 5'd9;
    bus.readReg2  = 5'd10;
    #1;
    checks++;
    if (bus.readData1 !== 32'hB || bus.readData2 !== 32'hC0DE) begin
      failures++;
      $display("FAIL bypass_indep rd1=%h rd2=%h required=%h/%h",
               bus.readData1, bus.readData2, 32'hB, 32'hC0DE);
    end
    @(posedge clk);
    #1;
    bus.regWrite = 1'b0;
    // wrCount: 8, 9(A), 9(B), 10 -> 4
    checks++;
    if (bus.wrCount !== 16'd4) begin
      failures++;
      $display("FAIL bypass_count actual=%0d required=4", bus.wrCount);
    end
  endtask

  task automatic test_no_write();
    do_write(5'd3, 32'h33);
    @(negedge clk);
    bus.regWrite  = 1'b0;
    bus.writeReg  = 5'd3;
    bus.writeData = 32'h55;
    bus.readReg1  = 5'd3;
    bus.dbgAddr   = 5'd3;
    #1;
    checks++;
    if (bus.readData1 !== 32'h33) begin
      failures++;
      $display("FAIL no_write_bypass actual=%h required=%h", bus.readData1, 32'h33);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.dbgData !== 32'h33 || bus.wrCount !== 16'd5) begin
      failures++;
      $display("FAIL no_write_hold dbg=%h cnt=%0d required=%h/5", bus.dbgData, bus.wrCount, 32'h33);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] exp_v;
    int            bad;
    for (int i = 1; i < 32; i++) begin
      do_write(AW'(i), DW'(i * 3));
    end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      bus.dbgAddr = AW'(i);
      #1;
      exp_v = DW'(i * 3);
      if (bus.dbgData !== exp_v) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL fill_readback bad_regs=%0d required=0", bad);
    end
    // reset between edges, with a qualified write presented at the same time
    @(negedge clk);
    bus.regWrite  = 1'b1;
    bus.writeReg  = 5'd4;
    bus.writeData = 32'h4444;
    bus.readReg1  = 5'd4;
    bus.readReg2  = 5'd7;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.wrCount !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid_count actual=%0d required=0", bus.wrCount);
    end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      bus.dbgAddr = AW'(i);
      #0.1;
      if (bus.dbgData !== 32'h0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_mid_clear bad_regs=%0d required=0", bad);
    end
    checks++;
    if (bus.readData1 !== 32'h4444 || bus.readData2 !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_ports rd1=%h rd2=%h required=%h/0", bus.readData1, bus.readData2, 32'h4444);
    end
    // reset wins over the write across a rising edge
    @(posedge clk);
    #1;
    bus.dbgAddr = 5'd4;
    #1;
    checks++;
    if (bus.dbgData !== 32'h0 || bus.wrCount !== 16'd0) begin
      failures++;
      $display("FAIL reset_wins dbg=%h cnt=%0d required=0/0", bus.dbgData, bus.wrCount);
    end
    // release; first edge with reset low commits the held write
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    bus.regWrite = 1'b0;
    #1;
    checks++;
    if (bus.dbgData !== 32'h4444 || bus.wrCount !== 16'd1) begin
      failures++;
      $display("FAIL post_reset_write dbg=%h cnt=%0d required=%h/1", bus.dbgData, bus.wrCount, 32'h4444);
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    @(negedge clk);
    bus.regWrite  = 1'b1;
    bus.writeReg  = 5'd5;
    bus.writeData = 32'h5A5A;
    bus.dbgAddr   = 5'd5;
    repeat (65534) @(posedge clk);
    #1;
    checks++;
    if (bus.wrCount !== 16'hFFFE) begin
      failures++;
      $display("FAIL sat_before actual=%h required=%h", bus.wrCount, 16'hFFFE);
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (bus.wrCount !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_hold actual=%h required=%h", bus.wrCount, 16'hFFFF);
    end
    checks++;
    if (bus.dbgData !== 32'h5A5A) begin
      failures++;
      $display("FAIL sat_data actual=%h required=%h", bus.dbgData, 32'h5A5A);
    end
    bus.regWrite = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // sequence and report
  // -------------------------------------------------------------------------
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_write_basic();
    test_write_r0();
    test_bypass();
    test_no_write();
    test_reset_mid();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
